// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator: format codes and the
// RV major opcodes that carry an immediate.
package imm_pkg;

   localparam int FMT_W = 3;

   typedef enum logic [FMT_W-1:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Occupancy limit of the result buffer.
   localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / result-out handshake bundle of the immediate generator.
interface imm_gen_pipe_if
   import imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  imm;
   logic [FMT_W-1:0] fmt;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   // Generator side.
   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, imm, fmt, illegal, illegal_cnt
   );

   // Producer / consumer side.
   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, imm, fmt, illegal, illegal_cnt
   );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Purely combinational opcode classification and immediate extraction.
// The 32-bit immediate is assembled as a signed value whose top bit is
// always instr[31], then sign-extended to XLEN.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]            instr,
   output logic signed [XLEN-1:0] imm,
   output fmt_e                   fmt,
   output logic                   illegal
);

   logic [6:0]         opcode;
   logic signed [31:0] raw;

   assign opcode = instr[6:0];

   // Classify the opcode and pick the bit layout of its immediate.
   always_comb begin
      fmt     = FMT_NONE;
      illegal = 1'b0;
      raw     = '0;
      unique case (opcode)
         OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
            fmt = FMT_I;
            raw = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            fmt = FMT_S;
            raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            raw = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt = FMT_J;
            raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
         end
         default: begin
            fmt     = FMT_NONE;
            illegal = 1'b1;
            raw     = '0;
         end
      endcase
   end

   // Signed size cast replicates raw[31] up to XLEN.
   assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: combinational decode feeding a 2-entry result
// buffer with valid/ready on both sides, plus a saturating counter of
// accepted illegal words. in_ready depends only on registered occupancy.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   imm_gen_pipe_if.slave bus
);

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Stage p0: decode of the incoming word
   logic signed [XLEN-1:0] dec_imm_p0;
   fmt_e                   dec_fmt_p0;
   logic                   dec_ill_p0;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (bus.instr),
      .imm     (dec_imm_p0),
      .fmt     (dec_fmt_p0),
      .illegal (dec_ill_p0)
   );

   // Stage p1: buffered results
   logic signed [XLEN-1:0]  buf_imm_p1 [BUF_DEPTH];
   logic [FMT_W-1:0]        buf_fmt_p1 [BUF_DEPTH];
   logic                    buf_ill_p1 [BUF_DEPTH];

   logic [1:0]       count_q;
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [CNT_W-1:0] ill_cnt_q;

   logic in_ready;
   logic vld_p1;
   logic acc;
   logic pop;

   assign in_ready = (count_q < 2'(BUF_DEPTH));
   assign vld_p1   = (count_q != 2'd0);
   assign acc      = bus.in_valid && in_ready;
   assign pop      = vld_p1 && bus.out_ready;

   // Data storage: written on accept only, never reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         buf_imm_p1[wr_ptr_q] <= dec_imm_p0;
         buf_fmt_p1[wr_ptr_q] <= dec_fmt_p0;
         buf_ill_p1[wr_ptr_q] <= dec_ill_p0;
      end
   end

   // Occupancy and 1-bit pointers; a simultaneous accept and pop keeps the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (acc) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({acc, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Count accepted illegal words, holding at the maximum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_cnt_q <= '0;
      end else if (acc && dec_ill_p0) begin
         ill_cnt_q <= sat_inc(ill_cnt_q);
      end
   end

   // Present the head entry, or zeros when the buffer is empty.
   always_comb begin
      bus.imm     = '0;
      bus.fmt     = FMT_NONE;
      bus.illegal = 1'b0;
      if (vld_p1) begin
         bus.imm     = buf_imm_p1[rd_ptr_q];
         bus.fmt     = buf_fmt_p1[rd_ptr_q];
         bus.illegal = buf_ill_p1[rd_ptr_q];
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = vld_p1;
   assign bus.illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit instance with a wide counter
// and a 32-bit instance with a 2-bit counter share clock and reset.
module tb_imm_gen_pipe;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_cnt64 = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(64), .CNT_W(16)) bus64 ();
   imm_gen_pipe_if #(.XLEN(32), .CNT_W(2))  bus32 ();

   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus64.slave)
   );

   imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   // Directed decode vectors: instruction, 64-bit immediate, fmt, illegal.
   logic [31:0] v_instr [12] = '{
      32'h00813083, 32'hFE113C23, 32'hFFDFF06F, 32'h800002B7,
      32'hFE000EE3, 32'h00000463, 32'hFFF00093, 32'h12345097,
      32'h00008067, 32'h0080006F, 32'h0010001B, 32'h00000033
   };
   logic [63:0] v_imm [12] = '{
      64'h0000000000000008, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
      64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000008,
      64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000, 64'h0000000000000000,
      64'h0000000000000008, 64'h0000000000000001, 64'h0000000000000000
   };
   logic [2:0] v_fmt [12] = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd3, 3'd3,
                              3'd1, 3'd4, 3'd1, 3'd5, 3'd1, 3'd0};
   logic       v_ill [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic test_reset();
      #1;
      n_cmp++; if (bus64.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus64.in_ready); end
      n_cmp++; if (bus64.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus64.out_valid); end
      n_cmp++; if (bus64.imm !== 64'd0) begin n_err++; $display("FAIL rst_imm: got %h want 0", bus64.imm); end
      n_cmp++; if (bus64.fmt !== 3'd0) begin n_err++; $display("FAIL rst_fmt: got %0d want 0", bus64.fmt); end
      n_cmp++; if (bus64.illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", bus64.illegal); end
      n_cmp++; if (bus64.illegal_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", bus64.illegal_cnt); end
      n_cmp++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready32: got %b want 1", bus32.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_illegal_cnt();
      n_cmp++; if (bus64.illegal_cnt !== 16'd0) begin n_err++; $display("FAIL ill_cnt_before: got %0d want 0", bus64.illegal_cnt); end
      bus64.in_valid  = 1'b1;
      bus64.instr     = 32'h00000000;
      bus64.out_ready = 1'b1;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      exp_cnt64 = 1;
      n_cmp++; if (bus64.out_valid !== 1'b1) begin n_err++; $display("FAIL ill_out_valid: got %b want 1", bus64.out_valid); end
      n_cmp++; if (bus64.illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag: got %b want 1", bus64.illegal); end
      n_cmp++; if (bus64.fmt !== 3'd0) begin n_err++; $display("FAIL ill_fmt: got %0d want 0", bus64.fmt); end
      n_cmp++; if (bus64.imm !== 64'd0) begin n_err++; $display("FAIL ill_imm: got %h want 0", bus64.imm); end
      n_cmp++; if (bus64.illegal_cnt !== 16'd1) begin n_err++; $display("FAIL ill_cnt_after: got %0d want 1", bus64.illegal_cnt); end
      @(negedge clk);
   endtask

   task automatic test_decode();
      for (int i = 0; i < 12; i++) begin
         n_cmp++; if (bus64.out_valid !== 1'b0) begin n_err++; $display("FAIL dec_empty[%0d]: got %b want 0", i, bus64.out_valid); end
         bus64.in_valid  = 1'b1;
         bus64.instr     = v_instr[i];
         bus64.out_ready = 1'b1;
         if (v_ill[i]) exp_cnt64++;
         @(negedge clk);
         bus64.in_valid = 1'b0;
         n_cmp++; if (bus64.out_valid !== 1'b1) begin n_err++; $display("FAIL dec_valid[%0d]: got %b want 1", i, bus64.out_valid); end
         n_cmp++; if (bus64.imm !== v_imm[i]) begin n_err++; $display("FAIL dec_imm[%0d]: got %h want %h", i, bus64.imm, v_imm[i]); end
         n_cmp++; if (bus64.fmt !== v_fmt[i]) begin n_err++; $display("FAIL dec_fmt[%0d]: got %0d want %0d", i, bus64.fmt, v_fmt[i]); end
         n_cmp++; if (bus64.illegal !== v_ill[i]) begin n_err++; $display("FAIL dec_ill[%0d]: got %b want %b", i, bus64.illegal, v_ill[i]); end
         n_cmp++; if (bus64.illegal_cnt !== 16'(exp_cnt64)) begin n_err++; $display("FAIL dec_cnt[%0d]: got %0d want %0d", i, bus64.illegal_cnt, exp_cnt64); end
         @(negedge clk);
      end
   endtask

   task automatic test_xlen32();
      bus32.in_valid  = 1'b1;
      bus32.instr     = 32'h800002B7;
      bus32.out_ready = 1'b1;
      @(negedge clk);
      bus32.instr = 32'hFE113C23;
      n_cmp++; if (bus32.imm !== 32'h80000000) begin n_err++; $display("FAIL x32_lui_imm: got %h want 80000000", bus32.imm); end
      n_cmp++; if (bus32.fmt !== 3'd4) begin n_err++; $display("FAIL x32_lui_fmt: got %0d want 4", bus32.fmt); end
      @(negedge clk);
      bus32.in_valid = 1'b0;
      n_cmp++; if (bus32.imm !== 32'hFFFFFFF8) begin n_err++; $display("FAIL x32_sd_imm: got %h want fffffff8", bus32.imm); end
      n_cmp++; if (bus32.fmt !== 3'd2) begin n_err++; $display("FAIL x32_sd_fmt: got %0d want 2", bus32.fmt); end
      @(negedge clk);
      n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL x32_drain: got %b want 0", bus32.out_valid); end
   endtask

   task automatic test_saturate();
      int exp;
      n_cmp++; if (bus32.illegal_cnt !== 2'd0) begin n_err++; $display("FAIL sat_start: got %0d want 0", bus32.illegal_cnt); end
      bus32.in_valid  = 1'b1;
      bus32.instr     = 32'h00000000;
      bus32.out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         exp = (k > 3) ? 3 : k;
         n_cmp++; if (bus32.illegal_cnt !== 2'(exp)) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, bus32.illegal_cnt, exp); end
      end
      bus32.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus32.illegal_cnt !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", bus32.illegal_cnt); end
   endtask

   task automatic test_back_to_back();
      bus64.out_ready = 1'b0;
      bus64.in_valid  = 1'b1;
      bus64.instr     = 32'h00100093;
      @(negedge clk);
      n_cmp++; if (bus64.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1: got %b want 1", bus64.in_ready); end
      bus64.instr = 32'h00200093;
      @(negedge clk);
      n_cmp++; if (bus64.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", bus64.in_ready); end
      n_cmp++; if (bus64.imm !== 64'd1) begin n_err++; $display("FAIL b2b_head_a: got %h want 1", bus64.imm); end
      bus64.instr = 32'h00300093;
      @(negedge clk);
      n_cmp++; if (bus64.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_held: got %b want 0", bus64.in_ready); end
      n_cmp++; if (bus64.imm !== 64'd1) begin n_err++; $display("FAIL b2b_stable: got %h want 1", bus64.imm); end
      n_cmp++; if (bus64.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_stable_vld: got %b want 1", bus64.out_valid); end
      bus64.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus64.imm !== 64'd2) begin n_err++; $display("FAIL b2b_out_b: got %h want 2", bus64.imm); end
      n_cmp++; if (bus64.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_again: got %b want 1", bus64.in_ready); end
      @(negedge clk);
      bus64.in_valid = 1'b0;
      n_cmp++; if (bus64.imm !== 64'd3) begin n_err++; $display("FAIL b2b_out_c: got %h want 3", bus64.imm); end
      n_cmp++; if (bus64.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_vld_c: got %b want 1", bus64.out_valid); end
      @(negedge clk);
      n_cmp++; if (bus64.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup: got %b want 0", bus64.out_valid); end
   endtask

   task automatic test_reset_mid();
      bus64.out_ready = 1'b0;
      bus64.in_valid  = 1'b1;
      bus64.instr     = 32'h00000000;
      @(negedge clk);
      bus64.instr = 32'h00100093;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      exp_cnt64++;
      n_cmp++; if (bus64.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: got %b want 0", bus64.in_ready); end
      n_cmp++; if (bus64.illegal_cnt !== 16'(exp_cnt64)) begin n_err++; $display("FAIL mid_cnt_pre: got %0d want %0d", bus64.illegal_cnt, exp_cnt64); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus64.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", bus64.out_valid); end
      n_cmp++; if (bus64.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", bus64.in_ready); end
      n_cmp++; if (bus64.illegal_cnt !== 16'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", bus64.illegal_cnt); end
      n_cmp++; if (bus64.imm !== 64'd0) begin n_err++; $display("FAIL mid_imm: got %h want 0", bus64.imm); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus64.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale: got %b want 0", bus64.out_valid); end
      bus64.in_valid  = 1'b1;
      bus64.instr     = 32'h00700093;
      bus64.out_ready = 1'b1;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      n_cmp++; if (bus64.imm !== 64'd7) begin n_err++; $display("FAIL mid_first_out: got %h want 7", bus64.imm); end
      n_cmp++; if (bus64.illegal !== 1'b0) begin n_err++; $display("FAIL mid_first_ill: got %b want 0", bus64.illegal); end
      @(negedge clk);
      n_cmp++; if (bus64.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_drain: got %b want 0", bus64.out_valid); end
   endtask

   initial begin
      bus64.in_valid  = 1'b0;
      bus64.instr     = 32'h0;
      bus64.out_ready = 1'b0;
      bus32.in_valid  = 1'b0;
      bus32.instr     = 32'h0;
      bus32.out_ready = 1'b0;
      test_reset();
      test_illegal_cnt();
      test_decode();
      test_xlen32();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
